traffic_timer: RTL and testbench

- Interval store and countdown timer for the traffic controller.
- Write side: the Reprogram / Time_Parameter_Selector / Time_Value programming interface writes the three interval registers (base, extended, yellow).
- Read side: the controller FSM selects an interval and pulses Start_Timer. The block reads the stored value, counts it down in 1-second ticks from an internal clock divider, and pulses Expired.

---
 rtl/traffic_timer_if.sv | 34 +++
 rtl/traffic_timer.sv | 126 ++++++++++++
 tb/tb_traffic_timer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_timer_if.sv
// traffic_timer_if: programming, start and status signals between the traffic
// controller (master) and the interval timer (slave).
// Optional macro TRAFFIC_TIMER_REMAINING_EN adds the Remaining status field.
interface traffic_timer_if;
    logic       Reprogram;
    logic [1:0] Time_Parameter_Selector;
    logic [3:0] Time_Value;
    logic [1:0] Interval;
    logic       Start_Timer;
    logic       Busy;
    logic       Expired;
    logic       Tick_1Hz;
`ifdef TRAFFIC_TIMER_REMAINING_EN
    logic [3:0] Remaining;

    modport master (
        output Reprogram, Time_Parameter_Selector, Time_Value, Interval, Start_Timer,
        input  Busy, Expired, Tick_1Hz, Remaining
    );
    modport slave (
        input  Reprogram, Time_Parameter_Selector, Time_Value, Interval, Start_Timer,
        output Busy, Expired, Tick_1Hz, Remaining
    );
`else
    modport master (
        output Reprogram, Time_Parameter_Selector, Time_Value, Interval, Start_Timer,
        input  Busy, Expired, Tick_1Hz
    );
    modport slave (
        input  Reprogram, Time_Parameter_Selector, Time_Value, Interval, Start_Timer,
        output Busy, Expired, Tick_1Hz
    );
`endif
endinterface

// File: rtl/traffic_timer.sv
// traffic_timer: stores the base/extended/yellow intervals and counts the
// selected one down in 1-second ticks from a free-running clock divider.
// Optional macro TRAFFIC_TIMER_REMAINING_EN exposes the live count on Remaining.
module traffic_timer #(
    parameter int unsigned DIV_COUNT  = 100_000_000,
    parameter logic [3:0]  T_BASE_DEF = 4'd6,
    parameter logic [3:0]  T_EXT_DEF  = 4'd3,
    parameter logic [3:0]  T_YEL_DEF  = 4'd2
) (
    input  logic           clk,
    input  logic           Reset_n,
    traffic_timer_if.slave bus
);

    localparam int unsigned DIV_W = $clog2(DIV_COUNT);
    localparam int unsigned VAL_W = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [VAL_W-1:0]   count_q, count_d;
    logic [VAL_W-1:0]   base_q, base_d;
    logic [VAL_W-1:0]   ext_q, ext_d;
    logic [VAL_W-1:0]   yel_q, yel_d;
    logic               busy_q, busy_d;
    logic               expired_q, expired_d;
    logic               tick_q, tick_d;
    logic               div_wrap_c;
    logic               start_ok_c;
    logic [VAL_W-1:0]   sel_val_c;

    // Next-state logic: interval writes, divider, start/reload and countdown
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        base_d     = base_q;
        ext_d      = ext_q;
        yel_d      = yel_q;
        div_wrap_c = (div_q == DIV_LAST);
        div_d      = div_wrap_c ? '0 : div_q + DIV_W'(1);
        tick_d     = div_wrap_c;
        start_ok_c = bus.Start_Timer && (bus.Interval != 2'b11);

        // Start samples the old register contents, so a same-edge write
        // only takes effect from the next start.
        unique case (bus.Interval)
            2'b00:   sel_val_c = base_q;
            2'b01:   sel_val_c = ext_q;
            2'b10:   sel_val_c = yel_q;
            default: sel_val_c = '0;
        endcase

        if (bus.Reprogram) begin
            unique case (bus.Time_Parameter_Selector)
                2'b00:   base_d = bus.Time_Value;
                2'b01:   ext_d  = bus.Time_Value;
                2'b10:   yel_d  = bus.Time_Value;
                default: ;
            endcase
        end

        if (start_ok_c) begin
            // Start wins over tick and DONE; zero-length intervals run one second.
            state_d = S_COUNT;
            count_d = (sel_val_c == '0) ? VAL_W'(1) : sel_val_c;
            div_d   = '0;
        end else begin
            unique case (state_q)
                S_COUNT: begin
                    if (div_wrap_c) begin
                        if (count_q == VAL_W'(1)) begin
                            count_d = '0;
                            state_d = S_DONE;
                        end else begin
                            count_d = count_q - VAL_W'(1);
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d    = (state_d == S_COUNT);
        expired_d = (state_d == S_DONE);
    end

    // State, interval and output registers
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            count_q   <= '0;
            base_q    <= T_BASE_DEF;
            ext_q     <= T_EXT_DEF;
            yel_q     <= T_YEL_DEF;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            count_q   <= count_d;
            base_q    <= base_d;
            ext_q     <= ext_d;
            yel_q     <= yel_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Expired  = expired_q;
    assign bus.Tick_1Hz = tick_q;
`ifdef TRAFFIC_TIMER_REMAINING_EN
    assign bus.Remaining = count_q;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: directed stimulus for traffic_timer with DIV_COUNT=4.
// Stimulus pushes the cycle at which Expired must appear; a monitor pops and
// compares every Expired pulse and flags missing or unexpected pulses.
module tb_traffic_timer;

    localparam int D = 4;

    logic clk = 1'b0;
    logic Reset_n;
    int   cyc = 0;
    int   exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mon_e;

    traffic_timer_if tb_if();

    traffic_timer #(.DIV_COUNT(D)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (tb_if)
    );

    always #5 clk = ~clk;

    // Cycle index = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(input string name, input int act, input int req);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every Expired pulse must match the oldest expected cycle
    always @(negedge clk) begin
        if (tb_if.Expired === 1'b1) begin
            check("busy_with_expired", int'(tb_if.Busy), 0);
            if (exp_q.size() == 0) begin
                fail("unexpected_expired", cyc, -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("expired_cycle", cyc, mon_e);
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0]) begin
            mon_e = exp_q.pop_front();
            fail("missed_expired", cyc, mon_e);
        end
    end

    // Called at a falling edge; returns at the falling edge after the start edge E
    task automatic start(input logic [1:0] iv, input int n, input bit replace);
        if (replace && exp_q.size() != 0) void'(exp_q.pop_back());
        tb_if.Interval    = iv;
        tb_if.Start_Timer = 1'b1;
        if (n > 0) exp_q.push_back(cyc + 1 + n * D);
        @(negedge clk);
        tb_if.Start_Timer = 1'b0;
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] val);
        tb_if.Reprogram               = 1'b1;
        tb_if.Time_Parameter_Selector = sel;
        tb_if.Time_Value              = val;
        @(negedge clk);
        tb_if.Reprogram = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            fail("timeout_idle", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Hard stop in case the stimulus itself hangs
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        Reset_n                       = 1'b0;
        tb_if.Reprogram               = 1'b0;
        tb_if.Time_Parameter_Selector = 2'b00;
        tb_if.Time_Value              = 4'd0;
        tb_if.Interval                = 2'b00;
        tb_if.Start_Timer             = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(tb_if.Busy), 0);
        check("reset_expired", int'(tb_if.Expired), 0);
        check("reset_tick", int'(tb_if.Tick_1Hz), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Base interval: 6 s -> 24 busy cycles, tick 4 cycles after start
        start(2'b00, 6, 1'b0);
        busy_n = 0;
        for (int j = 0; j < 30; j++) begin
            if (tb_if.Busy) busy_n++;
            if (j == D - 1) check("tick_before_second", int'(tb_if.Tick_1Hz), 0);
            if (j == D)     check("tick_first_second", int'(tb_if.Tick_1Hz), 1);
            if (j == 24) begin
                check("busy_low_at_expiry", int'(tb_if.Busy), 0);
                check("expired_at_24", int'(tb_if.Expired), 1);
            end
`ifdef TRAFFIC_TIMER_REMAINING_EN
            if (j < 24)  check("remaining", int'(tb_if.Remaining), 6 - j / D);
            if (j == 24) check("remaining_done", int'(tb_if.Remaining), 0);
`endif
            @(negedge clk);
        end
        check("busy_cycles_base", busy_n, 24);
        wait_idle();

        // Yellow reprogrammed to 5, then reset restores 2
        prog(2'b10, 4'd5);
        start(2'b10, 5, 1'b0);
        wait_idle();
        Reset_n = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        start(2'b10, 2, 1'b0);
        wait_idle();

        // Extended = 0 runs one second; reserved selector writes nothing
        prog(2'b01, 4'd0);
        start(2'b01, 1, 1'b0);
        wait_idle();
        prog(2'b11, 4'd9);
        start(2'b00, 6, 1'b0);
        wait_idle();
        start(2'b01, 1, 1'b0);
        wait_idle();
        start(2'b10, 2, 1'b0);
        wait_idle();

        // Reload 10 cycles into a base countdown: only the yellow expiry appears
        start(2'b00, 6, 1'b0);
        repeat (9) @(negedge clk);
        start(2'b10, 2, 1'b1);
        wait_idle();

        // Asynchronous reset mid-count: Busy drops at once, no Expired later
        start(2'b00, 6, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset_busy", int'(tb_if.Busy), 0);
        check("async_reset_expired", int'(tb_if.Expired), 0);
        exp_q.delete();
        @(negedge clk);
        Reset_n = 1'b1;
        repeat (30) @(negedge clk);

        // Interval 11 start is ignored in IDLE
        tb_if.Interval    = 2'b11;
        tb_if.Start_Timer = 1'b1;
        @(negedge clk);
        tb_if.Start_Timer = 1'b0;
        repeat (2) @(negedge clk);
        check("invalid_start_busy", int'(tb_if.Busy), 0);
        repeat (30) @(negedge clk);

        // Start and write to the same register on one edge: old value is used
        tb_if.Reprogram               = 1'b1;
        tb_if.Time_Parameter_Selector = 2'b00;
        tb_if.Time_Value              = 4'd3;
        start(2'b00, 6, 1'b0);
        tb_if.Reprogram = 1'b0;
        wait_idle();
        start(2'b00, 3, 1'b0);
        wait_idle();

        // Start sampled during the DONE cycle restarts the countdown
        start(2'b10, 2, 1'b0);
        repeat (8) @(negedge clk);
        check("expired_before_restart", int'(tb_if.Expired), 1);
        start(2'b10, 2, 1'b0);
        wait_idle();
        check("idle_busy_final", int'(tb_if.Busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
